// File: rtl/seq_booth_multiplier.sv
// Radix-4 Booth sequential multiplier with per-operand signedness.
// One Booth step per clock, W/2+1 steps per operation, start/done handshake,
// busy flag and synchronous abort. Product is held until the next completion.
module seq_booth_multiplier #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           a_signed,
    input  logic           b_signed,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int ITER = W / 2 + 1;
    localparam int XW   = W + 2;
    localparam int HW   = W + 4;
    localparam int CW   = $clog2(ITER);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    mcand_q, mcand_d;
    logic [HW-1:0]    accHi_q, accHi_d;
    logic [XW-1:0]    accLo_q, accLo_d;
    logic             boothPrev_q, boothPrev_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*W-1:0]   product_q, product_d;
    logic             done_q, done_d;

    logic [2:0]       triplet;
    logic [HW-1:0]    multA;
    logic [HW-1:0]    multA2;
    logic [HW-1:0]    partial;
    logic [HW-1:0]    sum;
    logic [HW-1:0]    stepHi;
    logic [XW-1:0]    stepLo;
    logic             stepPrev;

    // One Booth step: pick 0/+-A/+-2A from the multiplier triplet, add to the upper half, shift right by 2
    always_comb begin
        triplet = {accLo_q[1:0], boothPrev_q};
        multA   = {{2{mcand_q[XW-1]}}, mcand_q};
        multA2  = {multA[HW-2:0], 1'b0};
        partial = '0;
        case (triplet)
            3'b001, 3'b010: partial = multA;
            3'b011:         partial = multA2;
            3'b100:         partial = -multA2;
            3'b101, 3'b110: partial = -multA;
            default:        partial = '0;
        endcase
        sum      = accHi_q + partial;
        stepHi   = {{2{sum[HW-1]}}, sum[HW-1:2]};
        stepLo   = {sum[1:0], accLo_q[XW-1:2]};
        stepPrev = accLo_q[1];
    end

    // Control: accept start in IDLE, run ITER steps in CALC, abort drops back to IDLE without a result
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        accHi_d     = accHi_q;
        accLo_d     = accLo_q;
        boothPrev_d = boothPrev_q;
        count_d     = count_q;
        product_d   = product_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d     = {{2{a_signed & a[W-1]}}, a};
                    accHi_d     = '0;
                    accLo_d     = {{2{b_signed & b[W-1]}}, b};
                    boothPrev_d = 1'b0;
                    count_d     = CW'(ITER - 1);
                    state_d     = CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    accHi_d     = stepHi;
                    accLo_d     = stepLo;
                    boothPrev_d = stepPrev;
                    if (count_q == '0) begin
                        product_d = {stepHi[W-3:0], stepLo};
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            accHi_q     <= '0;
            accLo_q     <= '0;
            boothPrev_q <= 1'b0;
            count_q     <= '0;
            product_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            accHi_q     <= accHi_d;
            accLo_q     <= accLo_d;
            boothPrev_q <= boothPrev_d;
            count_q     <= count_d;
            product_q   <= product_d;
            done_q      <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q == CALC);

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised radix-4 Booth sequential multiplier. It is the next generation of the 32-bit sequential_multiplier and keeps the same start/done style of interface. New capabilities:
- per-operand signed/unsigned mode;
- two product bits retired per cycle;
- a busy flag;
- a synchronous abort.

It sits beside the ALU as a multi-cycle execution unit, driven by a controller that issues start and waits for done.

Parameters:
W, 32, operand width in bits; must be even and >= 4.
ITER, W/2+1 (derived localparam, not overridable), number of Booth steps per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
abort  input  1  synchronous cancel of the operation in flight
a_signed  input  1  1: treat a as two's complement; 0: treat a as unsigned
b_signed  input  1  1: treat b as two's complement; 0: treat b as unsigned
a  input  W  multiplicand
b  input  W  multiplier
product  output  2W  result, held stable until the next completion
done  output  1  one-cycle completion pulse
busy  output  1  high while an operation is in progress

Behaviour:
- Reset: asynchronous and active-high. It forces state=IDLE, product=0, done=0, busy=0, and clears the internal registers and counter. Reset mid-operation discards the operation; no done is produced.
- States:
  - IDLE: busy=0. start=1 at edge E0 latches a, b, a_signed and b_signed, sets counter=ITER-1, moves to CALC and sets busy=1.
  - CALC: busy=1. Performs one Booth step per edge. At the last step (counter==0) it writes product, pulses done and returns to IDLE.
- Operand extension: each operand is extended to W+2 bits.
  - Sign extension when its *_signed bit is 1; zero extension otherwise.
  - This makes W+2 even and fits ITER radix-4 steps.
- Booth step:
  - Inspect the multiplier triplet {b[i+1], b[i], b[i-1]}, with b[-1]=0.
  - Select 0, ±A or ±2A, add it to the upper partial-product half, then arithmetic-shift right by 2.
  - The accumulator is W+4 bits wide on the upper half, so no intermediate overflow is possible.
- Result: the low 2W bits of the final accumulator are the exact product of the two interpreted operands. For the mixed-sign case the result is the two's-complement representation.
- Latency:
  - Start accepted at E0; steps occur at edges E1..E_ITER.
  - product updates and done=1 at E_ITER; done returns to 0 at E_ITER+1.
  - Latency is ITER cycles (17 for W=32).
  - busy is high from E0 up to E_ITER and low after E_ITER.
- Throughput: a start asserted while done=1 is accepted at that edge (busy=0), giving back-to-back operations with no bubble.
- start while busy=1: ignored. Operand inputs may change freely after E0 without affecting the result.
- abort:
  - While busy=1, abort=1 at an edge returns the block to IDLE. Results: busy=0, done stays 0, product keeps its previous value.
  - In IDLE, abort has no effect.
  - abort and start asserted in the same cycle while IDLE: start is accepted and the abort is ignored.
- product changes only at a completion edge or on reset.
- done is never asserted for more than one consecutive cycle unless back-to-back operations complete.

Test Plan:
1. Reset, then a=15, b=10, both signed, start for 1 cycle -> done exactly 17 cycles after the accepting edge, product=150; busy high for those 17 cycles.
2. Signed a=32'h80000000, b=32'h80000000 -> product=64'h4000000000000000. Signed a=-25, b=12 -> product=-300.
3. Unsigned a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001. Mixed: a_signed=1, a=32'hFFFFFFFF (-1), b_signed=0, b=32'hFFFFFFFF -> product=64'hFFFFFFFF00000001.
4. Start 7*6, then pulse start again with a=3, b=3 at cycle 5 -> second request ignored, product=42. Then re-assert start in the done cycle with a=10, b=11 -> accepted with no bubble, product=110 after 17 more cycles.
5. Start 5*5, assert abort at cycle 8 -> busy drops after that edge, done never pulses, product still 110. Assert rst during a new operation -> product=0, busy=0, done=0 immediately, without waiting for a clock edge.
6. Randomised: 1000 operations with random signedness bits and random a, b, checked against a 2W-bit reference model. Rerun with W=8 and W=16 overrides.
